score_keeper: RTL and testbench

- Game-round controller and score register for the reflex trainer.
- Counts hits and misses during a timed round and runs the round countdown.
- Keeps the best score of the session.
- Sits directly upstream of the on-screen score display: its `score` output (0..99) drives the display's 7-bit score input, and `best` feeds the home-screen best readout.

---
 rtl/score_keeper.sv | 152 +++++++++++++++
 tb/tb_score_keeper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: game-round controller and score register for the reflex trainer.
// It runs the round countdown and counts hits and misses during a timed round.
// It also keeps the best completed-round score of the session.
// Every output is registered, and reset is synchronous and active-low.
module score_keeper #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int ROUND_SEC   = 30,
  parameter int MAX_SCORE   = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [6:0] score,
  output logic [6:0] best,
  output logic [5:0] time_left,
  output logic [1:0] state,
  output logic       round_done,
  output logic       new_best
);

  localparam int              TW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0]   TICK_ONE   = TW'(1);
  localparam logic [TW-1:0]   TICK_ZERO  = TW'(0);
  localparam logic [5:0]      ROUND_LOAD = 6'(ROUND_SEC);
  localparam logic [6:0]      SCORE_MAX  = 7'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e          state_r, state_s;
  logic [6:0]      score_r, score_s;
  logic [6:0]      best_r, best_s;
  logic [5:0]      time_r, time_s;
  logic [TW-1:0]   tick_r, tick_s;
  logic            round_done_r, round_done_s;
  logic            new_best_r, new_best_s;

  // Saturating score step: limits are checked before the add/subtract so the
  // 7-bit value never wraps; a simultaneous hit and miss cancel out.
  function automatic logic [6:0] next_score(input logic [6:0] cur,
                                            input logic       h,
                                            input logic       m);
    logic [6:0] res;
    res = cur;
    if (h && !m) begin
      if (cur < SCORE_MAX) begin
        res = cur + 7'd1;
      end else begin
        res = cur;
      end
    end else if (m && !h) begin
      if (cur != 7'd0) begin
        res = cur - 7'd1;
      end else begin
        res = cur;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Next-state and next-output logic for the round controller.
  always_comb begin
    state_s      = state_r;
    score_s      = score_r;
    best_s       = best_r;
    time_s       = time_r;
    tick_s       = tick_r;
    round_done_s = 1'b0;
    new_best_s   = new_best_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s    = ST_PLAY;
          score_s    = 7'd0;
          time_s     = ROUND_LOAD;
          tick_s     = TICK_ZERO;
          new_best_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_PLAY: begin
        score_s = next_score(score_r, hit, miss);
        if (tick_r == TICK_LAST) begin
          tick_s = TICK_ZERO;
          time_s = time_r - 6'd1;
          if (time_r == 6'd1) begin
            // Final wrap: the best compare sees this cycle's score update.
            state_s      = ST_DONE;
            round_done_s = 1'b1;
            if (score_s > best_r) begin
              best_s     = score_s;
              new_best_s = 1'b1;
            end else begin
              best_s     = best_r;
              new_best_s = 1'b0;
            end
          end else begin
            state_s = ST_PLAY;
          end
        end else begin
          tick_s = tick_r + TICK_ONE;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean idle state.
        state_s    = ST_IDLE;
        score_s    = 7'd0;
        time_s     = 6'd0;
        tick_s     = TICK_ZERO;
        new_best_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      score_r      <= 7'd0;
      best_r       <= 7'd0;
      time_r       <= 6'd0;
      tick_r       <= TICK_ZERO;
      round_done_r <= 1'b0;
      new_best_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      score_r      <= score_s;
      best_r       <= best_s;
      time_r       <= time_s;
      tick_r       <= tick_s;
      round_done_r <= round_done_s;
      new_best_r   <= new_best_s;
    end
  end

  assign score      = score_r;
  assign best       = best_r;
  assign time_left  = time_r;
  assign state      = state_r;
  assign round_done = round_done_r;
  assign new_best   = new_best_r;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper.
// Two instances are used: A has TICK=4, ROUND=3 and MAX=99; B has TICK=20, ROUND=3 and MAX=5.
// A round-level reference model predicts every output cycle, and a monitor
// compares the predictions against the DUT outputs.
module tb_score_keeper;

  // Input vector encoding: {rst_n, start, hit, miss}
  localparam logic [3:0] V_RST   = 4'b0000;
  localparam logic [3:0] V_IDLE  = 4'b1000;
  localparam logic [3:0] V_START = 4'b1100;
  localparam logic [3:0] V_HIT   = 4'b1010;
  localparam logic [3:0] V_MISS  = 4'b1001;
  localparam logic [3:0] V_HM    = 4'b1011;

  typedef struct {
    int st;       // 0 idle, 1 play, 2 done
    int score;
    int best;
    int elapsed;  // cycles spent in the current round
    int nb;
    int rd;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0, start_a = 1'b0, hit_a = 1'b0, miss_a = 1'b0;
  logic rst_n_b = 1'b0, start_b = 1'b0, hit_b = 1'b0, miss_b = 1'b0;
  logic [6:0] score_a, best_a, score_b, best_b;
  logic [5:0] time_a, time_b;
  logic [1:0] state_a, state_b;
  logic rd_a, nb_a, rd_b, nb_b;

  mdl_t ma, mb;
  mdl_t qa[$];
  mdl_t qb[$];
  int vectors = 0;
  int miscompares = 0;
  bit drv_done = 1'b0;

  always #5 clk = ~clk;

  score_keeper #(.TICK_CYCLES(4), .ROUND_SEC(3), .MAX_SCORE(99)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .hit(hit_a), .miss(miss_a),
    .score(score_a), .best(best_a), .time_left(time_a), .state(state_a),
    .round_done(rd_a), .new_best(nb_a)
  );

  score_keeper #(.TICK_CYCLES(20), .ROUND_SEC(3), .MAX_SCORE(5)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .hit(hit_b), .miss(miss_b),
    .score(score_b), .best(best_b), .time_left(time_b), .state(state_b),
    .round_done(rd_b), .new_best(nb_b)
  );

  // Reference model: one clock of game rules, described at the round level.
  function automatic mdl_t mstep(mdl_t m, logic [3:0] v, int tick, int rsec, int maxs);
    mdl_t n;
    n = m;
    n.rd = 0;
    if (!v[3]) begin
      n.st = 0; n.score = 0; n.best = 0; n.elapsed = 0; n.nb = 0;
    end else if (m.st == 1) begin
      if (v[1] && !v[0]) n.score = (m.score + 1 > maxs) ? maxs : m.score + 1;
      if (v[0] && !v[1]) n.score = (m.score - 1 < 0) ? 0 : m.score - 1;
      n.elapsed = m.elapsed + 1;
      if (n.elapsed == tick * rsec) begin
        n.st = 2;
        n.rd = 1;
        n.nb = (n.score > m.best) ? 1 : 0;
        if (n.score > m.best) n.best = n.score;
      end
    end else if (v[2]) begin
      n.st = 1; n.score = 0; n.elapsed = 0; n.nb = 0;
    end
    return n;
  endfunction

  // Drive one clock of stimulus into both DUTs and queue the predicted outputs.
  task automatic step(input logic [3:0] va, input logic [3:0] vb);
    @(negedge clk);
    {rst_n_a, start_a, hit_a, miss_a} = va;
    {rst_n_b, start_b, hit_b, miss_b} = vb;
    ma = mstep(ma, va, 4, 3, 99);
    qa.push_back(ma);
    mb = mstep(mb, vb, 20, 3, 5);
    qb.push_back(mb);
  endtask

  task automatic steps_a(input logic [3:0] va, input int n);
    for (int i = 0; i < n; i++) step(va, V_IDLE);
  endtask

  task automatic steps_b(input logic [3:0] vb, input int n);
    for (int i = 0; i < n; i++) step(V_IDLE, vb);
  endtask

  function automatic logic [3:0] rand_vec();
    logic [3:0] v;
    v[3] = ($urandom_range(0, 99) != 0);
    v[2] = ($urandom_range(0, 14) == 0);
    v[1] = ($urandom_range(0, 2) == 0);
    v[0] = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  // Monitor: pops one prediction per DUT each cycle and compares it with the outputs.
  initial begin : monitor
    mdl_t e;
    int etl;
    int tail;
    tail = 0;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        etl = (e.st == 1) ? 3 - e.elapsed / 4 : 0;
        vectors++;
        if (score_a !== 7'(e.score) || best_a !== 7'(e.best) || time_a !== 6'(etl) ||
            state_a !== 2'(e.st) || rd_a !== 1'(e.rd) || nb_a !== 1'(e.nb)) begin
          miscompares++;
          $display("FAIL dut_a t=%0t got score=%0d best=%0d time=%0d state=%0d rd=%0b nb=%0b expected score=%0d best=%0d time=%0d state=%0d rd=%0d nb=%0d",
                   $time, score_a, best_a, time_a, state_a, rd_a, nb_a,
                   e.score, e.best, etl, e.st, e.rd, e.nb);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        etl = (e.st == 1) ? 3 - e.elapsed / 20 : 0;
        vectors++;
        if (score_b !== 7'(e.score) || best_b !== 7'(e.best) || time_b !== 6'(etl) ||
            state_b !== 2'(e.st) || rd_b !== 1'(e.rd) || nb_b !== 1'(e.nb)) begin
          miscompares++;
          $display("FAIL dut_b t=%0t got score=%0d best=%0d time=%0d state=%0d rd=%0b nb=%0b expected score=%0d best=%0d time=%0d state=%0d rd=%0d nb=%0d",
                   $time, score_b, best_b, time_b, state_b, rd_b, nb_b,
                   e.score, e.best, etl, e.st, e.rd, e.nb);
        end
      end
      if (drv_done) begin
        tail++;
        if (tail == 3) begin
          vectors++;
          if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL drain got qa=%0d qb=%0d expected 0 0", qa.size(), qb.size());
          end
          $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
          $finish;
        end
      end
    end
  end

  // Stimulus: directed round scenarios first, then random traffic on both DUTs.
  initial begin : driver
    step(V_RST, V_RST);
    step(V_RST, V_RST);
    // Pulses in IDLE are ignored.
    steps_a(V_HIT, 2);
    steps_a(V_MISS, 1);
    // Plain 12-cycle round.
    steps_a(V_START, 1);
    steps_a(V_IDLE, 14);
    // Hit x5, miss x2, hit+miss -> best 3, new_best.
    steps_a(V_START, 1);
    steps_a(V_HIT, 5);
    steps_a(V_MISS, 2);
    steps_a(V_HM, 1);
    steps_a(V_IDLE, 6);
    // Pulses in DONE are ignored.
    steps_a(V_HIT, 2);
    steps_a(V_MISS, 1);
    // Tie with best -> no new_best.
    steps_a(V_START, 1);
    steps_a(V_HIT, 3);
    steps_a(V_IDLE, 11);
    // Misses from zero stay at zero.
    steps_a(V_START, 1);
    steps_a(V_MISS, 4);
    steps_a(V_IDLE, 10);
    // Start mid-PLAY does not reload the countdown.
    steps_a(V_START, 1);
    steps_a(V_IDLE, 5);
    steps_a(V_START, 1);
    steps_a(V_IDLE, 8);
    // Best 9, then reset mid-round with score 7.
    steps_a(V_START, 1);
    steps_a(V_HIT, 9);
    steps_a(V_IDLE, 5);
    steps_a(V_START, 1);
    steps_a(V_HIT, 7);
    steps_a(V_RST, 1);
    steps_a(V_IDLE, 2);
    steps_a(V_START, 1);
    steps_a(V_IDLE, 14);
    // DUT B: saturation at 5 over a 60-cycle round.
    steps_b(V_START, 1);
    steps_b(V_HIT, 8);
    steps_b(V_IDLE, 54);
    // DUT B: hit on the final wrap cycle lifts 4 to 5 and sets best.
    steps_b(V_RST, 1);
    steps_b(V_START, 1);
    steps_b(V_HIT, 4);
    steps_b(V_IDLE, 55);
    steps_b(V_HIT, 1);
    steps_b(V_IDLE, 3);
    // Random traffic on both DUTs.
    for (int i = 0; i < 900; i++) step(rand_vec(), rand_vec());
    drv_done = 1'b1;
  end

endmodule
